// File: rtl/plugin_mem_responder_pkg.sv
// Shared types for the plugin memory responder.
// Holds the FSM state encoding and the full-word byte-enable constant.
package plugin_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_RESP      = 2'd3
  } plugin_mem_state_t;

  localparam logic [3:0] RAM_WE_ALL = 4'b1111;

endpackage

// File: rtl/plugin_mem_responder.sv
// Serves one plugin word access at a time on a shared sync-RAM port,
// yielding to the CPU and answering with a single-cycle ready pulse.
module plugin_mem_responder
  import plugin_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned SIZE_BYTES   = 65536,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        plugin_req_i,
  input  logic        plugin_we_i,
  input  logic [31:0] plugin_addr_i,
  input  logic [31:0] plugin_wdata_i,
  output logic [31:0] plugin_rdata_o,
  output logic        plugin_ready_o,
  input  logic        cpu_busy_i,
  output logic        ram_en_o,
  output logic [3:0]  ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic [31:0] access_count_o
);

  localparam logic [31:0] LAST_OFF = 32'(SIZE_BYTES) - 32'd4;
  localparam logic [1:0]  LAT      = 2'(READ_LATENCY);

  if ((SIZE_BYTES % 4) != 0 || SIZE_BYTES < 4 || READ_LATENCY < 1 || READ_LATENCY > 3)
  begin : g_param_check
    $error("plugin_mem_responder: illegal SIZE_BYTES or READ_LATENCY");
  end

  plugin_mem_state_t r_state, w_state_next;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [1:0]  r_cnt;
  logic        r_legal;
  logic        r_err;
  logic [31:0] r_access_count;

  logic [31:0] w_offset;
  logic        w_illegal;

  // The lower-bound test keeps the subtraction from wrapping into the window.
  assign w_offset  = plugin_addr_i - BASE_ADDR;
  assign w_illegal = (plugin_addr_i[1:0] != 2'b00) ||
                     (plugin_addr_i < BASE_ADDR)   ||
                     (w_offset > LAST_OFF);

  assign plugin_rdata_o = r_rdata;
  assign err_o          = r_err;
  assign access_count_o = r_access_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    plugin_ready_o = 1'b0;
    ram_en_o       = 1'b0;
    ram_we_o       = 4'b0000;
    ram_addr_o     = 32'h0;
    ram_wdata_o    = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (plugin_req_i) w_state_next = w_illegal ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!cpu_busy_i) begin
          ram_en_o     = 1'b1;
          ram_we_o     = r_we ? RAM_WE_ALL : 4'b0000;
          ram_addr_o   = r_addr - BASE_ADDR;
          ram_wdata_o  = r_wdata;
          w_state_next = r_we ? ST_RESP : ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (r_cnt == 2'd1) w_state_next = ST_RESP;
      end
      ST_RESP: begin
        plugin_ready_o = 1'b1;
        w_state_next   = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we           <= 1'b0;
      r_addr         <= 32'h0;
      r_wdata        <= 32'h0;
      r_rdata        <= 32'h0;
      r_cnt          <= 2'd0;
      r_legal        <= 1'b0;
      r_err          <= 1'b0;
      r_access_count <= 32'h0;
    end else begin
      if (err_clr_i) r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (plugin_req_i) begin
            r_we    <= plugin_we_i;
            r_addr  <= plugin_addr_i;
            r_wdata <= plugin_wdata_i;
            r_legal <= !w_illegal;
            if (w_illegal) begin
              r_err   <= 1'b1;
              r_rdata <= 32'h0;
            end
          end
        end
        ST_ISSUE: begin
          if (!cpu_busy_i) begin
            r_cnt <= LAT;
            if (r_we) r_rdata <= 32'h0;
          end
        end
        ST_WAIT_DATA: begin
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd1) r_rdata <= ram_rdata_i;
        end
        ST_RESP: begin
          if (r_legal) r_access_count <= r_access_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_plugin_mem_responder.sv
// Directed bench for plugin_mem_responder: one L=1 instance for most
// scenarios and one L=3 instance for back-to-back reads.
module tb_plugin_mem_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned SZ    = 65536;
  localparam int          WORDS = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, req3, we, busy, err_clr;
  logic [31:0] addr, wdata;

  logic [31:0] rdata1, ram_addr1, ram_wdata1, ram_rdata1, count1;
  logic        ready1, ram_en1, err1;
  logic [3:0]  ram_we1;
  logic [31:0] rdata3, ram_addr3, ram_wdata3, ram_rdata3, count3;
  logic        ready3, ram_en3, err3;
  logic [3:0]  ram_we3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  plugin_mem_responder #(.BASE_ADDR(BASE), .SIZE_BYTES(SZ), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .plugin_req_i(req), .plugin_we_i(we), .plugin_addr_i(addr), .plugin_wdata_i(wdata),
    .plugin_rdata_o(rdata1), .plugin_ready_o(ready1), .cpu_busy_i(busy),
    .ram_en_o(ram_en1), .ram_we_o(ram_we1), .ram_addr_o(ram_addr1), .ram_wdata_o(ram_wdata1),
    .ram_rdata_i(ram_rdata1), .err_o(err1), .err_clr_i(err_clr), .access_count_o(count1)
  );

  plugin_mem_responder #(.BASE_ADDR(BASE), .SIZE_BYTES(SZ), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .plugin_req_i(req3), .plugin_we_i(we), .plugin_addr_i(addr), .plugin_wdata_i(wdata),
    .plugin_rdata_o(rdata3), .plugin_ready_o(ready3), .cpu_busy_i(busy),
    .ram_en_o(ram_en3), .ram_we_o(ram_we3), .ram_addr_o(ram_addr3), .ram_wdata_o(ram_wdata3),
    .ram_rdata_i(ram_rdata3), .err_o(err3), .err_clr_i(err_clr), .access_count_o(count3)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'hA5C3_0000 ^ 32'(i);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h0000_3FFF);
  endfunction

  // Synchronous RAM models: L=1 and L=3 read pipelines, preset with pat().
  logic [31:0] mem1 [0:WORDS-1];
  logic [31:0] mem3 [0:WORDS-1];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [0:2];
  bit init1 = 1'b0;
  bit init3 = 1'b0;

  always @(posedge clk) begin
    if (!init1) begin
      for (int i = 0; i < WORDS; i++) mem1[i] <= pat(i);
      init1 <= 1'b1;
    end else if (ram_en1 && ram_we1 == 4'hF) mem1[widx(ram_addr1)] <= ram_wdata1;
    pipe1 <= (ram_en1 && ram_we1 == 4'h0) ? mem1[widx(ram_addr1)] : 32'hBAD0_BAD0;
  end
  assign ram_rdata1 = pipe1;

  always @(posedge clk) begin
    if (!init3) begin
      for (int i = 0; i < WORDS; i++) mem3[i] <= pat(i);
      init3 <= 1'b1;
    end else if (ram_en3 && ram_we3 == 4'hF) mem3[widx(ram_addr3)] <= ram_wdata3;
    pipe3[0] <= (ram_en3 && ram_we3 == 4'h0) ? mem3[widx(ram_addr3)] : 32'hBAD0_BAD0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign ram_rdata3 = pipe3[2];

  // Results of the most recent access() on the L=1 instance.
  int          t_rdy, t_en_cyc, t_en_cnt, t_zviol;
  logic [3:0]  t_we;
  logic [31:0] t_addr, t_wd, t_rd;
  logic        t_extra;

  // Call at posedge+2; the current cycle becomes cycle 0 of the access.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int busy_n, input logic clr);
    req = 1'b1; we = w; addr = a; wdata = d; err_clr = clr; busy = 1'b0;
    t_rdy = -1; t_en_cyc = -1; t_en_cnt = 0; t_zviol = 0;
    t_we = 4'h0; t_addr = 32'h0; t_wd = 32'h0; t_rd = 32'h0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      err_clr = 1'b0;
      busy = (c <= busy_n);
      #1;
      if (ram_en1) begin
        t_en_cnt++;
        if (t_en_cyc < 0) t_en_cyc = c;
        t_we = ram_we1; t_addr = ram_addr1; t_wd = ram_wdata1;
      end else if (ram_we1 != 4'h0 || ram_addr1 != 32'h0 || ram_wdata1 != 32'h0) begin
        t_zviol++;
      end
      if (ready1) begin
        t_rdy = c; t_rd = rdata1;
        break;
      end
    end
    req = 1'b0; busy = 1'b0;
    @(posedge clk); #2;
    t_extra = ready1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 1'b0; req3 = 1'b0; we = 1'b0; busy = 1'b0; err_clr = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({ready1, ram_en1, ram_we1, err1} !== 7'h0 || rdata1 !== 32'h0 || count1 !== 32'h0 ||
        ram_addr1 !== 32'h0 || ram_wdata1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b en=%b we=%h err=%b rdata=%h count=%h addr=%h wdata=%h required all 0",
               ready1, ram_en1, ram_we1, err1, rdata1, count1, ram_addr1, ram_wdata1);
    end
    reset = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic test_write_read;
    access(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 0, 1'b0);
    checks++;
    if (t_rdy !== 2 || t_en_cyc !== 1 || t_en_cnt !== 1 || t_zviol !== 0) begin
      failures++;
      $display("FAIL write_timing: ready_cyc=%0d en_cyc=%0d en_cnt=%0d zero_viol=%0d required 2 1 1 0",
               t_rdy, t_en_cyc, t_en_cnt, t_zviol);
    end
    checks++;
    if (t_we !== 4'hF || t_addr !== 32'h10 || t_wd !== 32'hDEAD_BEEF || t_rd !== 32'h0) begin
      failures++;
      $display("FAIL write_ram_port: we=%h addr=%h wdata=%h rdata=%h required f 00000010 deadbeef 00000000",
               t_we, t_addr, t_wd, t_rd);
    end
    checks++;
    if (t_extra !== 1'b0) begin
      failures++;
      $display("FAIL write_ready_pulse: ready after pulse=%b required 0", t_extra);
    end
    access(1'b0, BASE + 32'h10, 32'h0, 0, 1'b0);
    checks++;
    if (t_rdy !== 3 || t_en_cyc !== 1 || t_we !== 4'h0 || t_addr !== 32'h10 || t_rd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL read_back: ready_cyc=%0d en_cyc=%0d we=%h addr=%h rdata=%h required 3 1 0 00000010 deadbeef",
               t_rdy, t_en_cyc, t_we, t_addr, t_rd);
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (rdata1 !== 32'hDEAD_BEEF || count1 !== 32'd2) begin
      failures++;
      $display("FAIL rdata_hold_count: rdata=%h count=%0d required deadbeef 2", rdata1, count1);
    end
  endtask

  task automatic test_reset_mid_read;
    bit pulsed;
    req = 1'b1; we = 1'b0; addr = BASE + 32'h40;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b1;
    req = 1'b0;
    #1;
    checks++;
    if (ready1 !== 1'b0 || ram_en1 !== 1'b0 || count1 !== 32'h0 || rdata1 !== 32'h0 || err1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: ready=%b en=%b count=%h rdata=%h err=%b required all 0",
               ready1, ram_en1, count1, rdata1, err1);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    pulsed = 1'b0;
    repeat (4) begin
      @(posedge clk); #2;
      if (ready1) pulsed = 1'b1;
    end
    checks++;
    if (pulsed !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_ready: ready pulse seen=%b required 0", pulsed);
    end
    access(1'b0, BASE + 32'h40, 32'h0, 0, 1'b0);
    checks++;
    if (t_rdy !== 3 || t_rd !== pat(16) || count1 !== 32'd1) begin
      failures++;
      $display("FAIL reset_reissue: ready_cyc=%0d rdata=%h count=%0d required 3 %h 1",
               t_rdy, t_rd, count1, pat(16));
    end
  endtask

  task automatic test_contention;
    access(1'b0, BASE + 32'h100, 32'h0, 3, 1'b0);
    checks++;
    if (t_rdy !== 6 || t_en_cyc !== 4 || t_en_cnt !== 1 || t_zviol !== 0 || t_rd !== pat(64)) begin
      failures++;
      $display("FAIL contention: ready_cyc=%0d en_cyc=%0d en_cnt=%0d zero_viol=%0d rdata=%h required 6 4 1 0 %h",
               t_rdy, t_en_cyc, t_en_cnt, t_zviol, t_rd, pat(64));
    end
  endtask

  task automatic test_errors;
    logic [31:0] c0;
    c0 = count1;
    access(1'b0, BASE + SZ, 32'h0, 0, 1'b0);
    checks++;
    if (t_rdy !== 1 || t_rd !== 32'h0 || err1 !== 1'b1 || t_en_cnt !== 0 || count1 !== c0) begin
      failures++;
      $display("FAIL err_above_window: ready_cyc=%0d rdata=%h err=%b en_cnt=%0d count=%0d required 1 0 1 0 %0d",
               t_rdy, t_rd, err1, t_en_cnt, count1, c0);
    end
    err_clr = 1'b1;
    @(posedge clk); #2;
    err_clr = 1'b0;
    checks++;
    if (err1 !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: err=%b required 0", err1);
    end
    access(1'b1, BASE + 32'h2, 32'h1234_5678, 0, 1'b0);
    checks++;
    if (t_rdy !== 1 || t_rd !== 32'h0 || err1 !== 1'b1 || t_en_cnt !== 0 || count1 !== c0) begin
      failures++;
      $display("FAIL err_misaligned: ready_cyc=%0d rdata=%h err=%b en_cnt=%0d count=%0d required 1 0 1 0 %0d",
               t_rdy, t_rd, err1, t_en_cnt, count1, c0);
    end
    access(1'b0, BASE - 32'h4, 32'h0, 0, 1'b1);
    checks++;
    if (t_rdy !== 1 || err1 !== 1'b1 || t_en_cnt !== 0 || count1 !== c0) begin
      failures++;
      $display("FAIL err_below_set_wins: ready_cyc=%0d err=%b en_cnt=%0d count=%0d required 1 1 0 %0d",
               t_rdy, err1, t_en_cnt, count1, c0);
    end
    access(1'b0, BASE + SZ - 32'h4, 32'h0, 0, 1'b0);
    checks++;
    if (t_rdy !== 3 || t_en_cnt !== 1 || t_addr !== SZ - 32'h4 || t_rd !== pat(WORDS - 1) ||
        count1 !== c0 + 32'd1) begin
      failures++;
      $display("FAIL last_word_legal: ready_cyc=%0d en_cnt=%0d addr=%h rdata=%h count=%0d required 3 1 %h %h %0d",
               t_rdy, t_en_cnt, t_addr, t_rd, count1, SZ - 32'h4, pat(WORDS - 1), c0 + 32'd1);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] c0;
    int k;
    c0 = count3;
    k = 0;
    we = 1'b0; busy = 1'b0;
    addr = BASE + 32'h200;
    req3 = 1'b1;
    for (int c = 1; c <= 60 && k < 4; c++) begin
      @(posedge clk); #2;
      if (ready3) begin
        checks++;
        if (c !== 5 + 6 * k || rdata3 !== pat(128 + k)) begin
          failures++;
          $display("FAIL b2b_read%0d: ready_cyc=%0d rdata=%h required %0d %h",
                   k, c, rdata3, 5 + 6 * k, pat(128 + k));
        end
        k++;
        if (k == 4) req3 = 1'b0;
        else addr = BASE + 32'h200 + 32'(4 * k);
      end
    end
    req3 = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (k !== 4 || count3 !== c0 + 32'd4 || err3 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_summary: responses=%0d count=%0d err=%b required 4 %0d 0", k, count3, err3, c0 + 32'd4);
    end
  endtask

  task automatic test_counter_wrap;
    force dut.r_access_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_access_count;
    @(posedge clk); #2;
    access(1'b1, BASE + 32'h20, 32'h0BAD_CAFE, 0, 1'b0);
    checks++;
    if (t_rdy !== 2 || count1 !== 32'h0) begin
      failures++;
      $display("FAIL counter_wrap: ready_cyc=%0d count=%h required 2 00000000", t_rdy, count1);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_reset_mid_read();
    test_contention();
    test_errors();
    test_back_to_back();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
